// File: rtl/sys_clk_tick_master_pkg.sv
// Shared definitions for the system tick master: timer register map,
// control word bits, FSM state encoding and the period-to-load helper.
package sys_clk_tick_pkg;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_PERIODL = 3'd2;
    localparam logic [2:0] REG_PERIODH = 3'd3;
    localparam logic [2:0] REG_SNAPL   = 3'd4;
    localparam logic [2:0] REG_SNAPH   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    // Interrupt enabled, continuous reload, counting started
    localparam logic [15:0] CTRL_RUN_WORD  = 16'((1 << CTRL_ITO) | (1 << CTRL_CONT) | (1 << CTRL_START));
    localparam logic [15:0] CTRL_STOP_WORD = 16'(1 << CTRL_STOP);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_WAIT_IRQ,
        ST_CLR_ST,
        ST_SNAP_WR,
        ST_RD_SL,
        ST_RD_SH,
        ST_WR_STOP
    } tick_state_e;

    // The timer counts load+1 cycles per period; a zero period is clamped to load 0
    function automatic logic [31:0] load_value(input logic [31:0] period);
        return (period == 32'd0) ? 32'd0 : period - 32'd1;
    endfunction

endpackage

// File: rtl/sys_clk_tick_master_if.sv
// Avalon-MM bus between the tick master and the interval timer slave port.
interface sys_clk_tick_master_if;

    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        output avm_readdata,
        output avm_waitrequest
    );

endinterface

// File: rtl/sys_clk_tick_master_bus_port.sv
// Single-access Avalon-MM engine. The caller holds req/we/addr/wdata steady
// until done; read data is captured one cycle after the accepted read and
// presented together with the register index it came from.
module sys_clk_tick_bus_port (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req,
    input  logic                         we,
    input  logic [2:0]                   addr,
    input  logic [15:0]                  wdata,
    output logic                         done,
    output logic                         rd_valid,
    output logic [2:0]                   rd_addr,
    output logic [15:0]                  rdata,
    sys_clk_tick_master_if.master        avm
);

    logic       rd_pending;
    logic [2:0] pend_addr;

    // Bus drives straight from the request so the access holds for as long as waitrequest does
    assign avm.avm_chipselect = req;
    assign avm.avm_write_n    = ~(req & we);
    assign avm.avm_address    = req ? addr : 3'd0;
    assign avm.avm_writedata  = (req & we) ? wdata : 16'd0;
    assign done               = req & ~avm.avm_waitrequest;

    // Remember that an accepted read is owed data on the next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pending <= 1'b0;
            pend_addr  <= 3'd0;
        end else begin
            rd_pending <= done & ~we;
            if (done && !we) begin
                pend_addr <= addr;
            end
        end
    end

    // Capture the slave's read data in the cycle after the accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_addr  <= 3'd0;
            rdata    <= 16'd0;
        end else begin
            rd_valid <= rd_pending;
            if (rd_pending) begin
                rd_addr <= pend_addr;
                rdata   <= avm.avm_readdata;
            end
        end
    end

endmodule

// File: rtl/sys_clk_tick_master.sv
// Avalon-MM master owning the interval timer: programs period and control on
// start, then services each timer IRQ (status clear, tick count, optional
// counter snapshot) until a stop request is honoured.
module sys_clk_tick_master
    import sys_clk_tick_pkg::*;
#(
    parameter int unsigned TICK_W  = 32,
    parameter int unsigned SNAP_EN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [31:0]           period_cycles,
    sys_clk_tick_master_if.master avm,
    input  logic                  irq,
    output logic                  busy,
    output logic                  tick_pulse,
    output logic [TICK_W-1:0]     tick_count,
    output logic [31:0]           last_snapshot
);

    tick_state_e state;
    tick_state_e next_state;

    logic [31:0] load_reg;
    logic        stop_latch;
    logic        irq_guard;
    logic [15:0] snap_low;
    logic        start_accept;

    logic        bus_req;
    logic        bus_we;
    logic [2:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_done;
    logic        rd_valid;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;

    sys_clk_tick_bus_port u_bus_port (
        .clk      (clk),
        .reset    (reset),
        .req      (bus_req),
        .we       (bus_we),
        .addr     (bus_addr),
        .wdata    (bus_wdata),
        .done     (bus_done),
        .rd_valid (rd_valid),
        .rd_addr  (rd_addr),
        .rdata    (rd_data),
        .avm      (avm)
    );

    assign start_accept = (state == ST_IDLE) && start && !stop;
    assign busy         = (state != ST_IDLE);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the one bus access each state owns
    always_comb begin
        next_state = state;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = 3'd0;
        bus_wdata  = 16'd0;
        unique case (state)
            ST_IDLE: begin
                if (start_accept) begin
                    next_state = ST_WR_PL;
                end
            end
            ST_WR_PL: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = REG_PERIODL;
                bus_wdata = load_reg[15:0];
                if (bus_done) next_state = ST_WR_PH;
            end
            ST_WR_PH: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = REG_PERIODH;
                bus_wdata = load_reg[31:16];
                if (bus_done) next_state = ST_WR_CTRL;
            end
            ST_WR_CTRL: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = REG_CONTROL;
                bus_wdata = CTRL_RUN_WORD;
                if (bus_done) next_state = ST_WAIT_IRQ;
            end
            ST_WAIT_IRQ: begin
                if (stop_latch) begin
                    next_state = ST_WR_STOP;
                end else if (irq && !irq_guard) begin
                    next_state = ST_CLR_ST;
                end
            end
            ST_CLR_ST: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = REG_STATUS;
                bus_wdata = 16'd0;
                if (bus_done) next_state = (SNAP_EN != 0) ? ST_SNAP_WR : ST_WAIT_IRQ;
            end
            ST_SNAP_WR: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = REG_SNAPL;
                bus_wdata = 16'd0;
                if (bus_done) next_state = ST_RD_SL;
            end
            ST_RD_SL: begin
                bus_req  = 1'b1;
                bus_addr = REG_SNAPL;
                if (bus_done) next_state = ST_RD_SH;
            end
            ST_RD_SH: begin
                bus_req  = 1'b1;
                bus_addr = REG_SNAPH;
                if (bus_done) next_state = ST_WAIT_IRQ;
            end
            ST_WR_STOP: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = REG_CONTROL;
                bus_wdata = CTRL_STOP_WORD;
                if (bus_done) next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Sample the timer load value only in the cycle start is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_reg <= 32'd0;
        end else if (start_accept) begin
            load_reg <= load_value(period_cycles);
        end
    end

    // Stop request latch: set while running, dropped in IDLE and once the stop write lands
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stop_latch <= 1'b0;
        end else if (state == ST_IDLE) begin
            stop_latch <= 1'b0;
        end else if (state == ST_WR_STOP && bus_done) begin
            stop_latch <= 1'b0;
        end else if (stop) begin
            stop_latch <= 1'b1;
        end
    end

    // Tick accounting; the guard masks the level irq for the cycle it takes the timer to drop it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_count <= '0;
            tick_pulse <= 1'b0;
            irq_guard  <= 1'b0;
        end else begin
            tick_pulse <= 1'b0;
            irq_guard  <= 1'b0;
            if (state == ST_WR_CTRL && bus_done) begin
                tick_count <= '0;
            end
            if (state == ST_CLR_ST && bus_done) begin
                tick_pulse <= 1'b1;
                irq_guard  <= 1'b1;
                tick_count <= tick_count + TICK_W'(1);
            end
        end
    end

    // Stage the low snapshot half so last_snapshot only ever changes as a whole word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_low      <= 16'd0;
            last_snapshot <= 32'd0;
        end else if (rd_valid) begin
            if (rd_addr == REG_SNAPL) begin
                snap_low <= rd_data;
            end else if (rd_addr == REG_SNAPH) begin
                last_snapshot <= {rd_data, snap_low};
            end
        end
    end

endmodule

// File: tb/tb_sys_clk_tick_master.sv
// Self-checking bench for sys_clk_tick_master: a bus monitor compares every
// accepted access against a queue of expected accesses, a small slave model
// returns read data with one cycle of latency and drops irq after a status clear.
module tb_sys_clk_tick_master;

    typedef struct {
        bit          we;
        logic [2:0]  addr;
        logic [15:0] data;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] period_cycles = 32'd0;
    logic        irq = 1'b0;
    logic        busy;
    logic        tick_pulse;
    logic [3:0]  tick_count;
    logic [31:0] last_snapshot;

    sys_clk_tick_master_if bus ();

    sys_clk_tick_master #(
        .TICK_W  (4),
        .SNAP_EN (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .period_cycles (period_cycles),
        .avm           (bus),
        .irq           (irq),
        .busy          (busy),
        .tick_pulse    (tick_pulse),
        .tick_count    (tick_count),
        .last_snapshot (last_snapshot)
    );

    always #5 clk = ~clk;

    int          n_compared = 0;
    int          n_mismatched = 0;
    int          tick_pulses = 0;
    acc_t        exp_q[$];
    logic [15:0] rd_q[$];
    acc_t        mon_e;
    bit          rd_pending = 0;
    bit          clr_seen = 0;
    bit          clr_d = 0;
    bit          auto_clear = 1;
    logic [3:0]  exp_ticks = 4'd0;
    logic [31:0] exp_snap = 32'd0;

    // Bus monitor: every accepted access must match the head of the expected queue
    always @(negedge clk) begin
        if (!reset) begin
            if (tick_pulse) tick_pulses++;
            if (bus.avm_chipselect && !bus.avm_waitrequest) begin
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL bus_unexpected: got we=%0b addr=%0d data=%h, required no access",
                             !bus.avm_write_n, bus.avm_address, bus.avm_writedata);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ((!bus.avm_write_n) !== mon_e.we || bus.avm_address !== mon_e.addr ||
                        (mon_e.we && bus.avm_writedata !== mon_e.data)) begin
                        n_mismatched++;
                        $display("[TB] FAIL bus_access: got we=%0b addr=%0d data=%h, required we=%0b addr=%0d data=%h",
                                 !bus.avm_write_n, bus.avm_address, bus.avm_writedata,
                                 mon_e.we, mon_e.addr, mon_e.data);
                    end
                end
                if (!bus.avm_write_n && bus.avm_address == 3'd0) clr_seen = 1;
                if (bus.avm_write_n) rd_pending = 1;
            end
        end
    end

    // Slave model: read data valid only in the cycle after the accept; irq drops a cycle after a status clear
    always @(posedge clk) begin
        #1;
        if (rd_pending) begin
            if (rd_q.size() > 0) bus.avm_readdata = rd_q.pop_front();
            else bus.avm_readdata = 16'hBAD0;
            rd_pending = 0;
        end else begin
            bus.avm_readdata = 16'hDEAD;
        end
        if (clr_d && auto_clear) irq = 1'b0;
        clr_d    = clr_seen;
        clr_seen = 0;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic push_acc(input bit we, input logic [2:0] addr, input logic [15:0] data);
        acc_t a;
        a.we = we; a.addr = addr; a.data = data;
        exp_q.push_back(a);
    endtask

    task automatic expect_program(input logic [31:0] p);
        logic [31:0] l;
        l = (p == 32'd0) ? 32'd0 : p - 32'd1;
        push_acc(1, 3'd2, l[15:0]);
        push_acc(1, 3'd3, l[31:16]);
        push_acc(1, 3'd1, 16'h0007);
        exp_ticks = 4'd0;
    endtask

    task automatic expect_service(input logic [15:0] lo, input logic [15:0] hi);
        push_acc(1, 3'd0, 16'h0000);
        push_acc(1, 3'd4, 16'h0000);
        push_acc(0, 3'd4, 16'h0000);
        push_acc(0, 3'd5, 16'h0000);
        rd_q.push_back(lo);
        rd_q.push_back(hi);
        exp_snap  = {hi, lo};
        exp_ticks = exp_ticks + 4'd1;
    endtask

    task automatic pulse_start(input logic [31:0] p);
        @(posedge clk); #1;
        period_cycles = p;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        period_cycles = 32'hDEAD_BEEF;
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL %s_drain: got %0d accesses outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_stop(input string name);
        push_acc(1, 3'd1, 16'h0008);
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_drain(name, 40);
        repeat (2) @(negedge clk);
        n_compared++;
        if (busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL %s_idle: got busy=%0b, required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_compared++;
        if ({bus.avm_chipselect, bus.avm_write_n, bus.avm_address} !== 5'b01_000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_bus: got cs=%0b wn=%0b addr=%0d, required cs=0 wn=1 addr=0",
                     bus.avm_chipselect, bus.avm_write_n, bus.avm_address);
        end
        n_compared++;
        if (bus.avm_writedata !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_wdata: got %h, required 0000", bus.avm_writedata);
        end
        n_compared++;
        if (busy !== 1'b0 || tick_pulse !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_flags: got busy=%0b tick_pulse=%0b, required 0 0", busy, tick_pulse);
        end
        n_compared++;
        if (tick_count !== 4'd0 || last_snapshot !== 32'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_counts: got tick_count=%0d snapshot=%h, required 0 00000000",
                     tick_count, last_snapshot);
        end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_program();
        logic [2:0] exp_addr [3];
        exp_addr = '{3'd2, 3'd3, 3'd1};
        expect_program(32'd50000);
        pulse_start(32'd50000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_compared++;
            if (bus.avm_chipselect !== 1'b1 || bus.avm_address !== exp_addr[i]) begin
                n_mismatched++;
                $display("[TB] FAIL program_cycle%0d: got cs=%0b addr=%0d, required cs=1 addr=%0d",
                         i, bus.avm_chipselect, bus.avm_address, exp_addr[i]);
            end
        end
        @(negedge clk);
        n_compared++;
        if (bus.avm_chipselect !== 1'b0 || busy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL program_wait: got cs=%0b busy=%0b, required cs=0 busy=1",
                     bus.avm_chipselect, busy);
        end
        wait_drain("program", 10);
    endtask

    task automatic test_tick();
        tick_pulses = 0;
        expect_service(16'h1234, 16'h0000);
        @(posedge clk); #1 irq = 1'b1;
        wait_drain("tick", 40);
        repeat (4) @(negedge clk);
        n_compared++;
        if (tick_count !== exp_ticks) begin
            n_mismatched++;
            $display("[TB] FAIL tick_count: got %0d, required %0d", tick_count, exp_ticks);
        end
        n_compared++;
        if (last_snapshot !== exp_snap) begin
            n_mismatched++;
            $display("[TB] FAIL tick_snapshot: got %h, required %h", last_snapshot, exp_snap);
        end
        n_compared++;
        if (tick_pulses !== 1) begin
            n_mismatched++;
            $display("[TB] FAIL tick_pulses: got %0d, required 1", tick_pulses);
        end
    endtask

    task automatic test_stop_during_snapshot();
        bit found;
        found = 0;
        auto_clear = 0;
        expect_service(16'hAAAA, 16'h5555);
        push_acc(1, 3'd1, 16'h0008);
        @(posedge clk); #1 irq = 1'b1;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (bus.avm_chipselect && bus.avm_write_n && bus.avm_address == 3'd4) found = 1;
        end
        n_compared++;
        if (!found) begin
            n_mismatched++;
            $display("[TB] FAIL stop_rd_sl_seen: got no snapshot-low read, required one");
        end
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_drain("stop", 40);
        repeat (4) @(negedge clk);
        n_compared++;
        if (busy !== 1'b0 || tick_count !== exp_ticks) begin
            n_mismatched++;
            $display("[TB] FAIL stop_state: got busy=%0b tick_count=%0d, required busy=0 tick_count=%0d",
                     busy, tick_count, exp_ticks);
        end
        n_compared++;
        if (last_snapshot !== exp_snap) begin
            n_mismatched++;
            $display("[TB] FAIL stop_snapshot: got %h, required %h", last_snapshot, exp_snap);
        end
        irq = 1'b0;
        auto_clear = 1;
    endtask

    task automatic test_waitrequest_hold();
        expect_program(32'h0001_2345);
        pulse_start(32'h0001_2345);
        @(posedge clk); #1 bus.avm_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.avm_waitrequest = 1'b0;
            @(negedge clk);
            n_compared++;
            if (bus.avm_chipselect !== 1'b1 || bus.avm_address !== 3'd3 || bus.avm_writedata !== 16'h0001) begin
                n_mismatched++;
                $display("[TB] FAIL wait_hold%0d: got cs=%0b addr=%0d data=%h, required cs=1 addr=3 data=0001",
                         i, bus.avm_chipselect, bus.avm_address, bus.avm_writedata);
            end
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        n_compared++;
        if (bus.avm_address !== 3'd1) begin
            n_mismatched++;
            $display("[TB] FAIL wait_next: got addr=%0d, required 1", bus.avm_address);
        end
        wait_drain("wait", 10);
        do_stop("wait_stop");
    endtask

    task automatic test_start_stop_idle();
        @(posedge clk); #1;
        start = 1'b1; stop = 1'b1; period_cycles = 32'd10;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_compared++;
            if (bus.avm_chipselect !== 1'b0 || busy !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL start_stop_idle%0d: got cs=%0b busy=%0b, required 0 0",
                         i, bus.avm_chipselect, busy);
            end
        end
        expect_program(32'd100);
        pulse_start(32'd100);
        wait_drain("restart", 10);
        pulse_start(32'd7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_compared++;
            if (busy !== 1'b1 || bus.avm_chipselect !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL busy_start_ignored%0d: got busy=%0b cs=%0b, required busy=1 cs=0",
                         i, busy, bus.avm_chipselect);
            end
        end
        do_stop("busy_stop");
    endtask

    task automatic test_period_zero_wrap();
        tick_pulses = 0;
        expect_program(32'd0);
        pulse_start(32'd0);
        wait_drain("zero", 10);
        for (int i = 1; i <= 17; i++) begin
            expect_service(16'(16'h0100 + i), 16'(16'h0A00 + i));
            @(posedge clk); #1 irq = 1'b1;
            wait_drain("wrap", 40);
            repeat (4) @(negedge clk);
            if (i == 15 || i == 17) begin
                n_compared++;
                if (tick_count !== exp_ticks) begin
                    n_mismatched++;
                    $display("[TB] FAIL wrap_count%0d: got %0d, required %0d", i, tick_count, exp_ticks);
                end
            end
        end
        n_compared++;
        if (tick_pulses !== 17 || last_snapshot !== exp_snap) begin
            n_mismatched++;
            $display("[TB] FAIL wrap_totals: got pulses=%0d snapshot=%h, required pulses=17 snapshot=%h",
                     tick_pulses, last_snapshot, exp_snap);
        end
        do_stop("wrap_stop");
    endtask

    task automatic test_reset_mid_access();
        bus.avm_waitrequest = 1'b1;
        pulse_start(32'd5);
        @(negedge clk);
        n_compared++;
        if (bus.avm_chipselect !== 1'b1 || bus.avm_address !== 3'd2) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_pre: got cs=%0b addr=%0d, required cs=1 addr=2",
                     bus.avm_chipselect, bus.avm_address);
        end
        #1 reset = 1'b1;
        #1;
        n_compared++;
        if (bus.avm_chipselect !== 1'b0 || bus.avm_write_n !== 1'b1 || busy !== 1'b0 || tick_count !== 4'd0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_release: got cs=%0b wn=%0b busy=%0b count=%0d, required 0 1 0 0",
                     bus.avm_chipselect, bus.avm_write_n, busy, tick_count);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        bus.avm_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        n_compared++;
        if (bus.avm_chipselect !== 1'b0 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_after: got cs=%0b busy=%0b, required 0 0", bus.avm_chipselect, busy);
        end
    endtask

    initial begin
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = 16'hDEAD;
        $display("[TB] starting sys_clk_tick_master bench");
        test_reset();
        test_program();
        test_tick();
        test_stop_during_snapshot();
        test_waitrequest_hold();
        test_start_stop_idle();
        test_period_zero_wrap();
        test_reset_mid_access();
        wait_drain("final", 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
